snes_button_events: RTL and testbench

//  Sits directly downstream of SNES_Wrapper. Consumes its 6-bit pressed-button vector (output_data).

---
 rtl/snes_button_events_if.sv | 30 +++
 rtl/snes_button_events.sv | 150 +++++++++++++++
 tb/tb_snes_button_events.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snes_button_events_if.sv
// Bus bundle between the CPU-side logic and snes_button_events.
//   buttons_raw : pressed-button vector from the SNES pad wrapper (1 = pressed)
//   rd_en       : pop the head event
//   clr_ovf     : clear the sticky overflow flag
//   rd_data     : head event {press/release, button_idx[2:0]}, 0 when empty
//   empty/count : FIFO status
//   overflow    : sticky lost-event flag
//   buttons_db  : debounced button levels
interface snes_button_events_if #(
  parameter int unsigned ADDR_W = 3
) ();
  logic [5:0]    buttons_raw;
  logic          rd_en;
  logic          clr_ovf;
  logic [3:0]    rd_data;
  logic          empty;
  logic [ADDR_W:0] count;
  logic          overflow;
  logic [5:0]    buttons_db;

  modport master (
    output buttons_raw, rd_en, clr_ovf,
    input  rd_data, empty, count, overflow, buttons_db
  );

  modport slave (
    input  buttons_raw, rd_en, clr_ovf,
    output rd_data, empty, count, overflow, buttons_db
  );
endinterface

// File: rtl/snes_button_events.sv
// Debounces the six SNES buttons, turns each debounced edge into an event
// code and queues the events in a show-ahead FIFO drained by a read strobe.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high; clears all state
//   bus   : snes_button_events_if.slave (raw buttons, read/clear strobes,
//           head event, FIFO status, overflow, debounced levels)
module snes_button_events #(
  parameter int unsigned SAMPLE_DIV     = 50000,
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned ADDR_W         = 3
) (
  input  logic               clk,
  input  logic               reset,
  snes_button_events_if.slave bus
);

  localparam int unsigned NB     = 6;
  localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DBC_W  = 4;

  logic [NB-1:0]            sync1, sync2;
  logic [TICK_W-1:0]        tick_cnt, tick_cnt_n;
  logic                     tick;
  logic [NB-1:0][DBC_W-1:0] db_cnt, db_cnt_n;
  logic [NB-1:0]            db, db_n, edge_v;
  logic [NB-1:0]            pend_valid, pend_valid_n;
  logic [NB-1:0]            pend_type, pend_type_n;
  logic [3:0]               mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]        rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0]         count_q, count_n;
  logic                     empty_q, empty_n;
  logic                     ovf_q, ovf_n, ovf_set;
  logic [3:0]               rd_data_q, rd_data_n;
  logic                     push, pop;
  logic [2:0]               push_idx;
  logic [3:0]               push_data;

  // Sample tick: one-cycle pulse when the free-running divider wraps.
  always_comb begin
    tick       = (tick_cnt == TICK_W'(SAMPLE_DIV - 1));
    tick_cnt_n = tick ? '0 : tick_cnt + TICK_W'(1);
  end

  // Per-button debounce: flip only after STABLE_SAMPLES consecutive differing ticks.
  always_comb begin
    db_n     = db;
    db_cnt_n = db_cnt;
    edge_v   = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (tick) begin
        if (sync2[i] == db[i]) begin
          db_cnt_n[i] = '0;
        end else if (db_cnt[i] == DBC_W'(STABLE_SAMPLES - 1)) begin
          db_n[i]     = sync2[i];
          db_cnt_n[i] = '0;
          edge_v[i]   = 1'b1;
        end else begin
          db_cnt_n[i] = db_cnt[i] + DBC_W'(1);
        end
      end
    end
  end

  // Pick the lowest-index pending button; push only if there is room before any pop.
  always_comb begin
    push_idx = '0;
    for (int i = int'(NB) - 1; i >= 0; i--) begin
      if (pend_valid[i]) push_idx = 3'(i);
    end
    push      = (|pend_valid) && (count_q < CNT_W'(FIFO_DEPTH));
    push_data = {pend_type[push_idx], push_idx};
    pop       = bus.rd_en && (count_q != '0);
  end

  // Pending slots, overflow and FIFO bookkeeping.
  always_comb begin
    pend_valid_n = pend_valid;
    pend_type_n  = pend_type;
    ovf_set      = 1'b0;
    if (push) pend_valid_n[push_idx] = 1'b0;
    for (int i = 0; i < int'(NB); i++) begin
      if (edge_v[i]) begin
        // A slot still holding an unqueued event loses it to the new edge.
        if (pend_valid_n[i]) ovf_set = 1'b1;
        pend_valid_n[i] = 1'b1;
        pend_type_n[i]  = db_n[i];
      end
    end
    ovf_n = ovf_set || (ovf_q && !bus.clr_ovf);

    rd_ptr_n = pop  ? rd_ptr + ADDR_W'(1) : rd_ptr;
    wr_ptr_n = push ? wr_ptr + ADDR_W'(1) : wr_ptr;
    case ({push, pop})
      2'b10:   count_n = count_q + CNT_W'(1);
      2'b01:   count_n = count_q - CNT_W'(1);
      default: count_n = count_q;
    endcase
    empty_n = (count_n == '0);

    // Registered show-ahead head; bypass the entry being written when it becomes the head.
    if (count_n == '0)                     rd_data_n = 4'h0;
    else if (push && (rd_ptr_n == wr_ptr)) rd_data_n = push_data;
    else                                   rd_data_n = mem[rd_ptr_n];
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      tick_cnt   <= '0;
      db_cnt     <= '0;
      db         <= '0;
      pend_valid <= '0;
      pend_type  <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      sync1      <= bus.buttons_raw;
      sync2      <= sync1;
      tick_cnt   <= tick_cnt_n;
      db_cnt     <= db_cnt_n;
      db         <= db_n;
      pend_valid <= pend_valid_n;
      pend_type  <= pend_type_n;
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      count_q    <= count_n;
      empty_q    <= empty_n;
      ovf_q      <= ovf_n;
      rd_data_q  <= rd_data_n;
      if (push) mem[wr_ptr] <= push_data;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.empty      = empty_q;
  assign bus.count      = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.buttons_db = db;

endmodule

// File: tb/tb_snes_button_events.sv
// Self-checking bench for snes_button_events: per-cycle comparison against a
// queue-based event model, a vector table, and directed multi-cycle sequences.
module tb_snes_button_events;

  localparam int SDIV   = 4;
  localparam int STABLE = 3;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  snes_button_events_if #(.ADDR_W(3)) bus ();

  snes_button_events #(
    .SAMPLE_DIV(SDIV), .STABLE_SAMPLES(STABLE), .FIFO_DEPTH(DEPTH), .ADDR_W(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [5:0] m_s1, m_s2, m_db, m_pv, m_pt;
  int         m_run [6];
  int         m_cyc;
  logic [3:0] m_q [$];
  logic       m_ovf;

  typedef struct {
    logic [5:0] raw;
    logic       rd;
    logic       clr;
    int         n;
    logic [5:0] e_db;
    int         e_count;
    logic [3:0] e_rd;
    logic       e_empty;
    logic       e_ovf;
  } vec_t;
  vec_t tbl [13];

  logic [5:0] raw_v;
  logic       found;
  logic [3:0] exp_ev;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_pv = '0; m_pt = '0;
    for (int i = 0; i < 6; i++) m_run[i] = 0;
    m_cyc = 0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // One clock of the behaviour: debounce on tick, queue lowest pending, pop head.
  task automatic model_step(input logic [5:0] raw, input logic rd, input logic clr);
    logic [5:0] edges = '0;
    int  pidx = -1;
    bit  room;
    bit  lost = 0;
    if ((m_cyc % SDIV) == SDIV - 1) begin
      for (int i = 0; i < 6; i++) begin
        if (m_s2[i] == m_db[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] >= STABLE) begin
            m_db[i] = m_s2[i];
            m_run[i] = 0;
            edges[i] = 1'b1;
          end
        end
      end
    end
    for (int i = 5; i >= 0; i--) if (m_pv[i]) pidx = i;
    room = (m_q.size() < DEPTH);
    if (rd && m_q.size() != 0) void'(m_q.pop_front());
    if (pidx >= 0 && room) begin
      m_q.push_back({m_pt[pidx], 3'(pidx)});
      m_pv[pidx] = 1'b0;
    end
    for (int i = 0; i < 6; i++) begin
      if (edges[i]) begin
        if (m_pv[i]) lost = 1;
        m_pv[i] = 1'b1;
        m_pt[i] = m_db[i];
      end
    end
    if (lost) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_s2 = m_s1;
    m_s1 = raw;
    m_cyc++;
  endtask

  task automatic compare_model();
    logic [3:0] head;
    head = (m_q.size() != 0) ? m_q[0] : 4'h0;
    check("model_rd_data", 32'(bus.rd_data), 32'(head));
    check("model_count", 32'(bus.count), 32'(m_q.size()));
    check("model_empty", 32'(bus.empty), 32'(m_q.size() == 0));
    check("model_overflow", 32'(bus.overflow), 32'(m_ovf));
    check("model_buttons_db", 32'(bus.buttons_db), 32'(m_db));
  endtask

  task automatic cycle(input logic [5:0] raw, input logic rd, input logic clr);
    bus.buttons_raw = raw;
    bus.rd_en = rd;
    bus.clr_ovf = clr;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(raw, rd, clr);
    #1;
    compare_model();
  endtask

  task automatic hold(input logic [5:0] raw, input int n);
    for (int i = 0; i < n; i++) cycle(raw, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{6'h00, 1'b0, 1'b0, 100, 6'h00, 0, 4'h0, 1'b1, 1'b0};
    tbl[1]  = '{6'h01, 1'b0, 1'b0, 24,  6'h01, 1, 4'h8, 1'b0, 1'b0};
    tbl[2]  = '{6'h01, 1'b1, 1'b0, 1,   6'h01, 0, 4'h0, 1'b1, 1'b0};
    tbl[3]  = '{6'h00, 1'b0, 1'b0, 24,  6'h00, 1, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{6'h00, 1'b1, 1'b0, 1,   6'h00, 0, 4'h0, 1'b1, 1'b0};
    tbl[5]  = '{6'h04, 1'b0, 1'b0, 8,   6'h00, 0, 4'h0, 1'b1, 1'b0};
    tbl[6]  = '{6'h00, 1'b0, 1'b0, 24,  6'h00, 0, 4'h0, 1'b1, 1'b0};
    tbl[7]  = '{6'h22, 1'b0, 1'b0, 24,  6'h22, 2, 4'h9, 1'b0, 1'b0};
    tbl[8]  = '{6'h22, 1'b1, 1'b0, 1,   6'h22, 1, 4'hD, 1'b0, 1'b0};
    tbl[9]  = '{6'h22, 1'b1, 1'b0, 1,   6'h22, 0, 4'h0, 1'b1, 1'b0};
    tbl[10] = '{6'h00, 1'b0, 1'b0, 24,  6'h00, 2, 4'h1, 1'b0, 1'b0};
    tbl[11] = '{6'h00, 1'b1, 1'b0, 1,   6'h00, 1, 4'h5, 1'b0, 1'b0};
    tbl[12] = '{6'h00, 1'b1, 1'b0, 1,   6'h00, 0, 4'h0, 1'b1, 1'b0};

    bus.buttons_raw = '0;
    bus.rd_en = 1'b0;
    bus.clr_ovf = 1'b0;
    model_reset();
    reset = 1'b1;
    hold(6'h00, 3);
    reset = 1'b0;

    // Vector table
    for (int v = 0; v < 13; v++) begin
      for (int c = 0; c < tbl[v].n; c++) cycle(tbl[v].raw, tbl[v].rd, tbl[v].clr);
      check($sformatf("tbl%0d_db", v), 32'(bus.buttons_db), 32'(tbl[v].e_db));
      check($sformatf("tbl%0d_count", v), 32'(bus.count), 32'(tbl[v].e_count));
      check($sformatf("tbl%0d_rd_data", v), 32'(bus.rd_data), 32'(tbl[v].e_rd));
      check($sformatf("tbl%0d_empty", v), 32'(bus.empty), 32'(tbl[v].e_empty));
      check($sformatf("tbl%0d_overflow", v), 32'(bus.overflow), 32'(tbl[v].e_ovf));
    end

    // Event becomes visible the cycle after the debounced level flips
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle(6'h01, 1'b0, 1'b0);
      found = bus.buttons_db[0];
    end
    check("edge_db_flip_seen", 32'(found), 32'd1);
    check("edge_empty_same_cycle", 32'(bus.empty), 32'd1);
    cycle(6'h01, 1'b0, 1'b0);
    check("edge_empty_next_cycle", 32'(bus.empty), 32'd0);
    check("edge_rd_data_next_cycle", 32'(bus.rd_data), 32'h8);
    cycle(6'h01, 1'b1, 1'b0);
    check("edge_pop_empty", 32'(bus.empty), 32'd1);
    hold(6'h00, 24);
    check("edge_release_code", 32'(bus.rd_data), 32'h0);
    cycle(6'h00, 1'b1, 1'b0);

    // Fill FIFO from bit 3 toggles, then hold the 9th and overwrite it with the 10th
    raw_v = 6'h00;
    for (int t = 1; t <= 10; t++) begin
      raw_v[3] = ~raw_v[3];
      hold(raw_v, 24);
      if (t == 8) check("full_count", 32'(bus.count), 32'd8);
      if (t == 9) begin
        check("full_pending_count", 32'(bus.count), 32'd8);
        check("full_pending_no_ovf", 32'(bus.overflow), 32'd0);
      end
    end
    check("overwrite_ovf", 32'(bus.overflow), 32'd1);
    for (int r = 0; r < 9; r++) begin
      exp_ev = (r % 2 == 0 && r != 8) ? 4'hB : 4'h3;
      check($sformatf("drain_%0d", r), 32'(bus.rd_data), 32'(exp_ev));
      cycle(raw_v, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_ovf_sticky", 32'(bus.overflow), 32'd1);
    cycle(raw_v, 1'b0, 1'b1);
    check("clr_ovf", 32'(bus.overflow), 32'd0);

    // Asynchronous reset with events queued and a debounce in progress
    raw_v = 6'h00;
    for (int t = 0; t < 5; t++) begin
      raw_v[4] = ~raw_v[4];
      hold(raw_v, 24);
    end
    check("pre_reset_count", 32'(bus.count), 32'd5);
    raw_v[0] = 1'b1;
    hold(raw_v, 6);
    reset = 1'b1;
    #1;
    check("async_rst_rd_data", 32'(bus.rd_data), 32'h0);
    check("async_rst_empty", 32'(bus.empty), 32'd1);
    check("async_rst_count", 32'(bus.count), 32'd0);
    check("async_rst_ovf", 32'(bus.overflow), 32'd0);
    check("async_rst_db", 32'(bus.buttons_db), 32'h00);
    hold(raw_v, 2);
    reset = 1'b0;
    hold(raw_v, 24);
    check("post_rst_count", 32'(bus.count), 32'd2);
    check("post_rst_first", 32'(bus.rd_data), 32'h8);
    cycle(raw_v, 1'b1, 1'b0);
    check("post_rst_second", 32'(bus.rd_data), 32'hC);
    cycle(raw_v, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) raw_v = raw_v ^ 6'($urandom_range(1, 63));
      cycle(raw_v, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
